// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core definitions for the write-back arbiter: source-select
// encoding and default register-file geometry.
package rf_wb_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    // Result source feeding the register-file write port.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    // The source that gets priority after the given one wins a tie.
    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 of the request/grant vectors is
// the ALU, bit 1 the LSU. A lone requester is always granted; on a tie the
// pointer decides and then flips to the other side.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    src_e ptr_q;
    src_e ptr_d;
    logic tie;

    assign tie = req_i[0] & req_i[1];

    // Grant: pass a single request straight through, resolve ties by pointer.
    always_comb begin
        gnt_o = req_i;
        if (tie) begin
            gnt_o = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
        end
    end

    // Pointer moves only on contested cycles so uncontested traffic cannot
    // skew fairness.
    always_comb begin
        ptr_d = ptr_q;
        if (tie) begin
            ptr_d = other_src(ptr_q);
        end
    end

    // Pointer register; ALU wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU and LSU results onto a single
// registered write port and keeps a per-register pending-write scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDR_WIDTH-1:0]    lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    input  logic                     iss_valid,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    output logic [2**ADDR_WIDTH-1:0] busy,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [1:0]            gnt;
    logic                  alu_xfer;
    logic                  lsu_xfer;
    src_e                  sel_src;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]       busy_q,     busy_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({lsu_valid, alu_valid}),
        .gnt_o (gnt)
    );

    // Ready is the grant itself, forced low while reset is asserted so no
    // producer sees a handshake during reset.
    assign alu_ready = gnt[0] & rst_n;
    assign lsu_ready = gnt[1] & rst_n;
    assign alu_xfer  = alu_valid & alu_ready;
    assign lsu_xfer  = lsu_valid & lsu_ready;

    // Select the transferring source's destination and data.
    always_comb begin
        sel_src  = alu_xfer ? SRC_ALU : SRC_LSU;
        sel_rd   = (sel_src == SRC_ALU) ? alu_rd   : lsu_rd;
        sel_data = (sel_src == SRC_ALU) ? alu_data : lsu_data;
    end

    // Write-port next state: x0 writes are consumed but never committed,
    // and address/data only change when a real write is launched.
    always_comb begin
        rf_wen_d   = (alu_xfer | lsu_xfer) && (sel_rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (rf_wen_d) begin
            rf_waddr_d = sel_rd;
            rf_wdata_d = sel_data;
        end
    end

    // Scoreboard: a new claim from issue beats a commit clearing the same
    // register at the same edge, since a newer producer is now outstanding.
    assign busy_d[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
        logic set_bit;
        logic clr_bit;
        assign set_bit    = iss_valid && (iss_rd == ADDR_WIDTH'(gi));
        assign clr_bit    = rf_wen_q && (rf_waddr_q == ADDR_WIDTH'(gi));
        assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
    end

    // State registers; reset discards any write already launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter followed by a short random-traffic
// section checked against a queue of accepted writes.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [AW-1:0]     alu_rd;
    logic [DW-1:0]     alu_data;
    logic              lsu_valid, lsu_ready;
    logic [AW-1:0]     lsu_rd;
    logic [DW-1:0]     lsu_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic [2**AW-1:0]  busy;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    int n_vec  = 0;
    int n_miss = 0;

    logic [AW+DW-1:0] expq[$];
    logic [AW+DW-1:0] exp_w;
    logic             alu_hold, lsu_hold;
    int               alu_wait, lsu_wait;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Compare a committed write against the oldest accepted transfer.
    task automatic check_write();
        if (rf_wen === 1'b1) begin
            if (expq.size() == 0) begin
                chk("rnd_unexpected_write", 32'(rf_waddr), 32'd0);
            end else begin
                exp_w = expq.pop_front();
                chk("rnd_waddr", 32'(rf_waddr), 32'(exp_w[AW+DW-1:DW]));
                chk("rnd_wdata", rf_wdata, exp_w[DW-1:0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b1; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        alu_hold = 1'b0; lsu_hold = 1'b0; alu_wait = 0; lsu_wait = 0;

        // During reset: no handshakes, outputs cleared
        #2;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        chk("rst_rf_wen",    32'(rf_wen),    32'd0);
        chk("rst_rf_wdata",  rf_wdata,       32'd0);
        chk("rst_busy",      busy,           32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;

        // ALU alone, rd3 <- 0x11
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        #1;
        chk("a_alu_ready", 32'(alu_ready), 32'd1);
        chk("a_lsu_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("a_wen",   32'(rf_wen),   32'd1);
        chk("a_waddr", 32'(rf_waddr), 32'd3);
        chk("a_wdata", rf_wdata,      32'h11);
        @(negedge clk);
        chk("a_wen_idle", 32'(rf_wen), 32'd0);
        chk("a_wdata_hold", rf_wdata,  32'h11);

        // Ties: ALU first after reset, then LSU, then ALU again
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hB;
        #1;
        chk("b_tie1_alu", 32'(alu_ready), 32'd1);
        chk("b_tie1_lsu", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        chk("b_w4_addr", 32'(rf_waddr), 32'd4);
        chk("b_w4_data", rf_wdata,      32'hA);
        alu_rd = 5'd6; alu_data = 32'hC;
        #1;
        chk("b_tie2_alu", 32'(alu_ready), 32'd0);
        chk("b_tie2_lsu", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        chk("b_w5_wen",  32'(rf_wen),   32'd1);
        chk("b_w5_addr", 32'(rf_waddr), 32'd5);
        chk("b_w5_data", rf_wdata,      32'hB);
        lsu_rd = 5'd8; lsu_data = 32'hD;
        #1;
        chk("b_tie3_alu", 32'(alu_ready), 32'd1);
        chk("b_tie3_lsu", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        chk("b_w6_addr", 32'(rf_waddr), 32'd6);
        chk("b_w6_data", rf_wdata,      32'hC);
        alu_valid = 1'b0;
        #1;
        chk("b_lone_lsu", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("b_w8_addr", 32'(rf_waddr), 32'd8);
        chk("b_w8_data", rf_wdata,      32'hD);
        @(negedge clk);
        chk("b_idle_wen", 32'(rf_wen), 32'd0);

        // LSU write to x0: accepted, never committed
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFF;
        #1;
        chk("c_x0_ready", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("c_x0_wen",   32'(rf_wen), 32'd0);
        chk("c_x0_wdata", rf_wdata,    32'hD);
        chk("c_x0_busy",  busy,        32'd0);

        // Scoreboard set/clear and set-wins collision on rd7
        iss_valid = 1'b1; iss_rd = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("d_busy_set", busy, 32'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("d_w7_wen",     32'(rf_wen),   32'd1);
        chk("d_w7_addr",    32'(rf_waddr), 32'd7);
        chk("d_busy_until", busy,          32'h80);
        iss_valid = 1'b1; iss_rd = 5'd7;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("d_set_wins", busy,         32'h80);
        chk("d_wen_off",  32'(rf_wen),  32'd0);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("d_w7b_data", rf_wdata, 32'h78);
        chk("d_busy_pre", busy,     32'h80);
        @(negedge clk);
        chk("d_busy_clr", busy, 32'd0);
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("d_busy_x0", busy, 32'd0);

        // Asynchronous reset with LSU rd9 write in flight
        iss_valid = 1'b1; iss_rd = 5'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        @(negedge clk);
        iss_valid = 1'b0;
        chk("e_w9_wen",  32'(rf_wen),   32'd1);
        chk("e_w9_addr", 32'(rf_waddr), 32'd9);
        chk("e_busy9",   busy,          32'h200);
        #1 rst_n = 1'b0;
        #1;
        chk("e_rst_wen",   32'(rf_wen),    32'd0);
        chk("e_rst_waddr", 32'(rf_waddr),  32'd0);
        chk("e_rst_wdata", rf_wdata,       32'd0);
        chk("e_rst_busy",  busy,           32'd0);
        chk("e_rst_ready", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; lsu_valid = 1'b0;
        @(negedge clk);
        chk("e_post_wen", 32'(rf_wen), 32'd0);

        // Pointer back to ALU after reset (it pointed to LSU before)
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2;
        #1;
        chk("f_tie_alu", 32'(alu_ready), 32'd1);
        chk("f_tie_lsu", 32'(lsu_ready), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("f_w1_addr", 32'(rf_waddr), 32'd1);
        @(negedge clk);
        chk("f_idle_wen", 32'(rf_wen), 32'd0);

        // Random traffic: held requests keep data stable until accepted
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            check_write();
            if (!alu_hold) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = AW'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!lsu_hold) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd    = AW'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = AW'($urandom_range(0, 31));
            #1;
            chk("rnd_one_grant", 32'(alu_ready & lsu_ready), 32'd0);
            alu_wait = (alu_valid && !alu_ready) ? alu_wait + 1 : 0;
            lsu_wait = (lsu_valid && !lsu_ready) ? lsu_wait + 1 : 0;
            if (alu_valid) chk("rnd_alu_starve", 32'(alu_wait > 1), 32'd0);
            if (lsu_valid) chk("rnd_lsu_starve", 32'(lsu_wait > 1), 32'd0);
            if (alu_valid && alu_ready && alu_rd != '0) expq.push_back({alu_rd, alu_data});
            if (lsu_valid && lsu_ready && lsu_rd != '0) expq.push_back({lsu_rd, lsu_data});
            alu_hold = alu_valid && !alu_ready;
            lsu_hold = lsu_valid && !lsu_ready;
        end
        @(negedge clk);
        check_write();
        alu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
        @(negedge clk);
        check_write();
        chk("rnd_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
